// File: rtl/arb_pkg.sv
// Shared types for the four-requester memory port arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [1:0]         sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic req_vec_t onehot(sel_t idx);
    return req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ... (mod 4).
module rr_pick4
  import arb_pkg::*;
(
  input  req_vec_t req,
  input  sel_t     ptr,
  output logic     any,
  output sel_t     idx
);

  // Scan from farthest to nearest so the nearest set bit is the one left standing.
  always_comb begin
    any = 1'b0;
    idx = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[ptr + sel_t'(i)]) begin
        any = 1'b1;
        idx = ptr + sel_t'(i);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of a single memory port shared by four requesters,
// with bounded bursts and same-cycle handoff on release.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter  int MAX_BURST = 4,
  localparam int CNT_W     = $clog2(MAX_BURST) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req_i,
  input  logic           mem_ready_i,
  output logic [3:0]     gnt_o,
  output logic [1:0]     sel_o,
  output logic           mem_valid_o,
  output logic [3:0]     beat_done_o,
  output logic           busy_o
);

  arb_state_t       state, state_n;
  sel_t             ptr, ptr_n;
  logic [CNT_W-1:0] beat_cnt, cnt_n, beat_n;
  req_vec_t         gnt_n;
  sel_t             sel_n;
  logic             valid_n;

  sel_t             pick_ptr;
  logic             pick_any;
  sel_t             pick_idx;

  // In BUSY the picker only matters at release, where priority starts after the owner.
  assign pick_ptr = (state == BUSY) ? sel_o + 2'd1 : ptr;

  rr_pick4 u_pick (
    .req (req_i),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      beat_cnt    <= '0;
      gnt_o       <= '0;
      sel_o       <= '0;
      mem_valid_o <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      beat_cnt    <= cnt_n;
      gnt_o       <= gnt_n;
      sel_o       <= sel_n;
      mem_valid_o <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = beat_cnt;
    gnt_n   = gnt_o;
    sel_n   = sel_o;
    valid_n = mem_valid_o;
    beat_n  = beat_cnt + CNT_W'(1);

    case (state)
      IDLE: begin
        if (pick_any) begin
          state_n = BUSY;
          gnt_n   = onehot(pick_idx);
          sel_n   = pick_idx;
          valid_n = 1'b1;
          cnt_n   = '0;
        end
      end
      BUSY: begin
        // The owner's request is only consulted when its beat completes.
        if (mem_ready_i) begin
          if (req_i[sel_o] && (beat_n < CNT_W'(MAX_BURST))) begin
            cnt_n = beat_n;
          end else begin
            ptr_n = pick_ptr;
            cnt_n = '0;
            if (pick_any) begin
              gnt_n = onehot(pick_idx);
              sel_n = pick_idx;
            end else begin
              state_n = IDLE;
              gnt_n   = '0;
              valid_n = 1'b0;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign beat_done_o = gnt_o & {4{mem_ready_i & mem_valid_o}};
  assign busy_o      = (state == BUSY);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared against an integer-level arbitration model.
module tb_mem_port_arbiter;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_i;
  logic       mem_ready_i;
  logic [3:0] gnt_o;
  logic [1:0] sel_o;
  logic       mem_valid_o;
  logic [3:0] beat_done_o;
  logic       busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_BURST(MB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .mem_ready_i (mem_ready_i),
    .gnt_o       (gnt_o),
    .sel_o       (sel_o),
    .mem_valid_o (mem_valid_o),
    .beat_done_o (beat_done_o),
    .busy_o      (busy_o)
  );

  wire logic [11:0] dut_vec = {gnt_o, sel_o, mem_valid_o, busy_o, beat_done_o};

  // Reference model: owner index (-1 when idle), beats taken, priority pointer, last select.
  typedef struct packed {
    int owner;
    int cnt;
    int ptr;
    int sel;
  } mstate_t;

  mstate_t m;

  function automatic int pick(logic [3:0] r, int p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  function automatic mstate_t model_step(mstate_t s, logic [3:0] r, logic rdy);
    mstate_t n;
    int k;
    n = s;
    if (s.owner < 0) begin
      k = pick(r, s.ptr);
      if (k >= 0) begin
        n.owner = k; n.sel = k; n.cnt = 0;
      end
    end else if (rdy) begin
      if (r[s.owner] && (s.cnt + 1 < MB)) begin
        n.cnt = s.cnt + 1;
      end else begin
        n.ptr = (s.owner + 1) % 4;
        n.cnt = 0;
        k = pick(r, n.ptr);
        if (k >= 0) begin
          n.owner = k; n.sel = k;
        end else begin
          n.owner = -1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{owner: -1, cnt: 0, ptr: 0, sel: 0};
    else        m <= model_step(m, req_i, mem_ready_i);
  end

  function automatic logic [11:0] exp_vec();
    logic [3:0] g;
    logic       act;
    act = (m.owner >= 0);
    g   = act ? (4'b0001 << m.owner) : 4'b0000;
    return {g, 2'(m.sel), act, act, g & {4{mem_ready_i}}};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_i = '0; mem_ready_i = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req_i = '0; mem_ready_i = 1'b0;
    #1 rst_n = 1'b0;
    #3;
    n_cmp++;
    if (dut_vec !== 12'h000) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected %h", dut_vec, 12'h000);
    end
    step(); step();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL reset_release: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_single();
    req_i = 4'b0100; mem_ready_i = 1'b0;
    step();
    n_cmp++;
    if ({gnt_o, sel_o, mem_valid_o} !== {4'b0100, 2'd2, 1'b1}) begin
      n_bad++; $display("FAIL single_grant: got %h expected %h", {gnt_o, sel_o, mem_valid_o}, {4'b0100, 2'd2, 1'b1});
    end
    req_i = 4'b0000; mem_ready_i = 1'b1;
    #1;
    n_cmp++;
    if (beat_done_o !== 4'b0100) begin
      n_bad++; $display("FAIL single_done: got %b expected %b", beat_done_o, 4'b0100);
    end
    step();
    mem_ready_i = 1'b0;
    #1;
    n_cmp++;
    if ({gnt_o, sel_o, mem_valid_o, busy_o, beat_done_o} !== {4'b0000, 2'd2, 1'b0, 1'b0, 4'b0000}) begin
      n_bad++; $display("FAIL single_idle: got %h expected %h", dut_vec, {4'b0000, 2'd2, 1'b0, 1'b0, 4'b0000});
    end
  endtask

  task automatic test_pointer_priority();
    int seen;
    seen = -1;
    req_i = 4'b0111; mem_ready_i = 1'b0;
    step();
    n_cmp++;
    if (gnt_o !== 4'b0001) begin
      n_bad++; $display("FAIL ptr_first_grant: got %b expected %b", gnt_o, 4'b0001);
    end
    mem_ready_i = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      #1;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL ptr_model c=%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
      if (seen < 0 && gnt_o === 4'b0100) seen = c;
    end
    n_cmp++;
    if (seen != 8) begin
      n_bad++; $display("FAIL ptr_req2_last: got %0d expected %0d", seen, 8);
    end
    mem_ready_i = 1'b0; req_i = '0;
  endtask

  task automatic test_burst_cap();
    int pulses;
    pulses = 0;
    do_reset();
    req_i = 4'b0001; mem_ready_i = 1'b1;
    step();
    for (int c = 0; c < MB; c++) begin
      #1;
      if (beat_done_o === 4'b0001) pulses++;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL burst_model c=%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
      step();
    end
    #1;
    n_cmp++;
    if ({pulses[3:0], gnt_o, mem_valid_o, busy_o} !== {4'(MB), 4'b0001, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL burst_regrant: got %h expected %h", {pulses[3:0], gnt_o, mem_valid_o, busy_o}, {4'(MB), 4'b0001, 1'b1, 1'b1});
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] es;
    logic [3:0] eg;
    do_reset();
    req_i = 4'b1111; mem_ready_i = 1'b1;
    step();
    for (int c = 0; c < 5 * MB; c++) begin
      #1;
      es = 2'((c / MB) % 4);
      eg = 4'b0001 << es;
      n_cmp++;
      if ({sel_o, gnt_o, beat_done_o} !== {es, eg, eg}) begin
        n_bad++; $display("FAIL rr_owner c=%0d: got %h expected %h", c, {sel_o, gnt_o, beat_done_o}, {es, eg, eg});
      end
      step();
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    req_i = 4'b0010; mem_ready_i = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      if (c >= 2) req_i = 4'b0000;
      #1;
      n_cmp++;
      if ({gnt_o, mem_valid_o, beat_done_o} !== {4'b0010, 1'b1, 4'b0000}) begin
        n_bad++; $display("FAIL wait_hold c=%0d: got %h expected %h", c, {gnt_o, mem_valid_o, beat_done_o}, {4'b0010, 1'b1, 4'b0000});
      end
      step();
    end
    mem_ready_i = 1'b1;
    #1;
    n_cmp++;
    if (beat_done_o !== 4'b0010) begin
      n_bad++; $display("FAIL wait_done: got %b expected %b", beat_done_o, 4'b0010);
    end
    step();
    mem_ready_i = 1'b0;
    #1;
    n_cmp++;
    if ({gnt_o, mem_valid_o, busy_o} !== {4'b0000, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL wait_release: got %h expected %h", {gnt_o, mem_valid_o, busy_o}, 6'b0);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_i = 4'b1000; mem_ready_i = 1'b1;
    step();
    step();
    mem_ready_i = 1'b0;
    #1;
    n_cmp++;
    if ({gnt_o, mem_valid_o} !== {4'b1000, 1'b1}) begin
      n_bad++; $display("FAIL midrst_owner: got %h expected %h", {gnt_o, mem_valid_o}, {4'b1000, 1'b1});
    end
    mem_ready_i = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec !== 12'h000) begin
      n_bad++; $display("FAIL midrst_clear: got %h expected %h", dut_vec, 12'h000);
    end
    step();
    rst_n = 1'b1; req_i = 4'b1001; mem_ready_i = 1'b0;
    step();
    n_cmp++;
    if (gnt_o !== 4'b0001) begin
      n_bad++; $display("FAIL midrst_regrant: got %b expected %b", gnt_o, 4'b0001);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_i       = 4'($urandom);
      mem_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL random c=%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pointer_priority();
    test_burst_cap();
    test_round_robin();
    test_wait_states();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
